// File: rtl/memory_interconnect_if.sv
// rtl/memory_interconnect_if.sv - master-side and slave-side pipelined Wishbone bundle of the crossbar
interface memory_interconnect_if #(
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 5
);
    localparam int SW = DW / 8;

    logic [N_MASTERS-1:0]    i_m_cyc;
    logic [N_MASTERS-1:0]    i_m_stb;
    logic [N_MASTERS-1:0]    i_m_we;
    logic [N_MASTERS*AW-1:0] i_m_addr;
    logic [N_MASTERS*DW-1:0] i_m_data;
    logic [N_MASTERS*SW-1:0] i_m_sel;
    logic [N_MASTERS-1:0]    o_m_ack;
    logic [N_MASTERS-1:0]    o_m_err;
    logic [N_MASTERS-1:0]    o_m_stall;
    logic [N_MASTERS*DW-1:0] o_m_data;

    logic [N_SLAVES-1:0]     o_s_cyc;
    logic [N_SLAVES-1:0]     o_s_stb;
    logic [N_SLAVES-1:0]     o_s_we;
    logic [N_SLAVES*AW-1:0]  o_s_addr;
    logic [N_SLAVES*DW-1:0]  o_s_data;
    logic [N_SLAVES*SW-1:0]  o_s_sel;
    logic [N_SLAVES-1:0]     i_s_ack;
    logic [N_SLAVES-1:0]     i_s_err;
    logic [N_SLAVES-1:0]     i_s_stall;
    logic [N_SLAVES*DW-1:0]  i_s_data;

    // The crossbar itself sits on the slave modport; the environment drives the master one.
    modport slave (
        input  i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data, i_m_sel,
        output o_m_ack, o_m_err, o_m_stall, o_m_data,
        output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
        input  i_s_ack, i_s_err, i_s_stall, i_s_data
    );

    modport master (
        output i_m_cyc, i_m_stb, i_m_we, i_m_addr, i_m_data, i_m_sel,
        input  o_m_ack, o_m_err, o_m_stall, o_m_data,
        input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
        output i_s_ack, i_s_err, i_s_stall, i_s_data
    );
endinterface

// File: rtl/memory_interconnect.sv
// rtl/memory_interconnect.sv - pipelined Wishbone crossbar with per-slave round-robin and per-master timeout
module memory_interconnect #(
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 5,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = {32'h3800_0000, 32'h3000_0000, 32'h2800_0000,
                                                    32'h2000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = {32'hF800_0000, 32'hF800_0000, 32'hF800_0000,
                                                    32'hF800_0000, 32'hE000_0000},
    parameter int MAX_OUT   = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic i_clk,
    input  logic i_reset_n,
    memory_interconnect_if.slave bus
);
    localparam int SW = DW / 8;
    localparam int MI = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SI = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [N_SLAVES-1:0]  own_vld, own_vld_n;
    logic [MI-1:0]        own_idx   [N_SLAVES];
    logic [MI-1:0]        own_idx_n [N_SLAVES];
    logic [MI-1:0]        rr_ptr    [N_SLAVES];
    logic [MI-1:0]        rr_ptr_n  [N_SLAVES];

    logic [CW-1:0]        outst     [N_MASTERS];
    logic [CW-1:0]        outst_n   [N_MASTERS];
    logic [TW-1:0]        tmr       [N_MASTERS];
    logic [TW-1:0]        tmr_n     [N_MASTERS];
    logic [N_MASTERS-1:0] ue_pend, ue_pend_n;
    logic [N_MASTERS-1:0] aborted, aborted_n;

    logic [N_MASTERS-1:0] mapped, gnt_vld, full, to_hit, accept, req, release_m;
    logic [SI-1:0]        tgt       [N_MASTERS];
    logic [SI-1:0]        gnt_slv   [N_MASTERS];

    // Address decode: iterate downwards so the lowest matching slave wins.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            mapped[m] = 1'b0;
            tgt[m]    = '0;
            for (int s = N_SLAVES - 1; s >= 0; s--) begin
                if ((bus.i_m_addr[m*AW +: AW] & SLAVE_MASK[s*AW +: AW]) == SLAVE_BASE[s*AW +: AW]) begin
                    mapped[m] = 1'b1;
                    tgt[m]    = SI'(s);
                end
            end
        end
    end

    // Reverse view of the owner table: which slave (if any) each master holds.
    always_comb begin
        for (int m = 0; m < N_MASTERS; m++) begin
            gnt_vld[m] = 1'b0;
            gnt_slv[m] = '0;
            for (int s = 0; s < N_SLAVES; s++) begin
                if (own_vld[s] && own_idx[s] == MI'(m)) begin
                    gnt_vld[m] = 1'b1;
                    gnt_slv[m] = SI'(s);
                end
            end
        end
    end

    // Per-master stall, response routing, outstanding tracking and timeout.
    always_comb begin
        logic cyc, stb, live, s_ack, s_err, ue_err, rsp, retarget;
        bus.o_m_ack   = '0;
        bus.o_m_err   = '0;
        bus.o_m_stall = '0;
        bus.o_m_data  = '0;
        ue_pend_n     = '0;
        aborted_n     = '0;
        full          = '0;
        to_hit        = '0;
        accept        = '0;
        req           = '0;
        release_m     = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            cyc    = bus.i_m_cyc[m];
            stb    = cyc & bus.i_m_stb[m];
            live   = gnt_vld[m] & cyc & ~aborted[m];
            s_ack  = live & bus.i_s_ack[gnt_slv[m]];
            s_err  = live & bus.i_s_err[gnt_slv[m]];
            ue_err = ue_pend[m] & cyc;
            rsp    = s_ack | s_err | ue_err;
            full[m]   = (outst[m] == CW'(MAX_OUT));
            to_hit[m] = cyc & ~aborted[m] & (outst[m] != '0) & (tmr[m] == TW'(TIMEOUT)) & ~rsp;

            if (aborted[m] || to_hit[m])
                bus.o_m_stall[m] = 1'b1;
            else if (stb && !mapped[m])
                bus.o_m_stall[m] = gnt_vld[m] | (outst[m] != '0);
            else if (stb)
                bus.o_m_stall[m] = ~(gnt_vld[m] && gnt_slv[m] == tgt[m]) | bus.i_s_stall[tgt[m]] | full[m];
            else
                bus.o_m_stall[m] = ~gnt_vld[m] | bus.i_s_stall[gnt_slv[m]] | full[m];

            accept[m] = stb & ~bus.o_m_stall[m];
            req[m]    = stb & mapped[m] & ~gnt_vld[m] & ~aborted[m];
            // A stb aimed elsewhere gives the current slave back only once the pipeline has drained.
            retarget  = stb & gnt_vld[m] & (~mapped[m] | (tgt[m] != gnt_slv[m])) & (outst[m] == '0);
            release_m[m] = ~cyc | to_hit[m] | aborted[m] | retarget;

            if (!cyc || to_hit[m])
                outst_n[m] = '0;
            else if (accept[m] && !rsp)
                outst_n[m] = outst[m] + CW'(1);
            else if (!accept[m] && rsp && outst[m] != '0)
                outst_n[m] = outst[m] - CW'(1);
            else
                outst_n[m] = outst[m];

            if (!cyc || to_hit[m] || accept[m] || rsp || outst[m] == '0)
                tmr_n[m] = '0;
            else
                tmr_n[m] = tmr[m] + TW'(1);

            ue_pend_n[m] = accept[m] & ~mapped[m];
            aborted_n[m] = cyc & (aborted[m] | to_hit[m]);

            bus.o_m_ack[m] = s_ack;
            bus.o_m_err[m] = s_err | ue_err | to_hit[m];
            if (live)
                bus.o_m_data[m*DW +: DW] = bus.i_s_data[gnt_slv[m]*DW +: DW];
        end
    end

    // Owner table: release has priority; a freed slave is re-granted no earlier than the following edge.
    always_comb begin
        logic found;
        int   idx;
        own_vld_n = own_vld;
        for (int s = 0; s < N_SLAVES; s++) begin
            own_idx_n[s] = own_idx[s];
            rr_ptr_n[s]  = rr_ptr[s];
            found        = 1'b0;
            idx          = 0;
            if (own_vld[s]) begin
                if (release_m[own_idx[s]])
                    own_vld_n[s] = 1'b0;
            end else begin
                for (int k = 0; k < N_MASTERS; k++) begin
                    idx = (int'(rr_ptr[s]) + k) % N_MASTERS;
                    if (!found && req[idx] && tgt[idx] == SI'(s)) begin
                        found        = 1'b1;
                        own_vld_n[s] = 1'b1;
                        own_idx_n[s] = MI'(idx);
                        rr_ptr_n[s]  = (idx == N_MASTERS - 1) ? '0 : MI'(idx + 1);
                    end
                end
            end
        end
    end

    // Forward the owner's request, translated into the slave's local address space.
    always_comb begin
        int   om;
        logic on, fwd;
        bus.o_s_cyc  = '0;
        bus.o_s_stb  = '0;
        bus.o_s_we   = '0;
        bus.o_s_addr = '0;
        bus.o_s_data = '0;
        bus.o_s_sel  = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            om  = int'(own_idx[s]);
            on  = own_vld[s] & bus.i_m_cyc[om] & ~aborted[om];
            fwd = on & bus.i_m_stb[om] & mapped[om] & (tgt[om] == SI'(s));
            bus.o_s_cyc[s] = on;
            if (fwd) begin
                bus.o_s_stb[s]              = ~full[om] & ~to_hit[om];
                bus.o_s_we[s]               = bus.i_m_we[om];
                bus.o_s_addr[s*AW +: AW]    = bus.i_m_addr[om*AW +: AW] & ~SLAVE_MASK[s*AW +: AW];
                bus.o_s_data[s*DW +: DW]    = bus.i_m_data[om*DW +: DW];
                bus.o_s_sel[s*SW +: SW]     = bus.i_m_sel[om*SW +: SW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            own_vld <= '0;
            ue_pend <= '0;
            aborted <= '0;
            for (int s = 0; s < N_SLAVES; s++) begin
                own_idx[s] <= '0;
                rr_ptr[s]  <= '0;
            end
            for (int m = 0; m < N_MASTERS; m++) begin
                outst[m] <= '0;
                tmr[m]   <= '0;
            end
        end else begin
            own_vld <= own_vld_n;
            ue_pend <= ue_pend_n;
            aborted <= aborted_n;
            for (int s = 0; s < N_SLAVES; s++) begin
                own_idx[s] <= own_idx_n[s];
                rr_ptr[s]  <= rr_ptr_n[s];
            end
            for (int m = 0; m < N_MASTERS; m++) begin
                outst[m] <= outst_n[m];
                tmr[m]   <= tmr_n[m];
            end
        end
    end
endmodule
